// File: rtl/uart_rx_pkg.sv
// Shared constants for the configurable UART receiver: FSM encoding, parity modes,
// error bit positions, register map and reset defaults.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAME   = 1;
  localparam int ERR_OVERRUN = 2;

  localparam int REG_CTRL = 0;
  localparam int REG_DIV  = 1;

  localparam int CTRL_DB_LSB   = 0;
  localparam int CTRL_DB_MSB   = 3;
  localparam int CTRL_PAR_LSB  = 4;
  localparam int CTRL_PAR_MSB  = 5;
  localparam int CTRL_STOP_BIT = 6;

  localparam logic [3:0] DEF_DATABITS = 4'd8;
  localparam logic [1:0] DEF_PARITY   = PAR_NONE;
  localparam logic       DEF_STOP2    = 1'b0;

  function automatic logic [3:0] clamp_databits(input logic [3:0] v, input logic [3:0] maxv);
    if (v < 4'd5) return 4'd5;
    if (v > maxv) return maxv;
    return v;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Configuration write bus shared with the command/display logic.
interface uart_rx_param_if #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 16
);
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
  logic [WIDTH_CONFIG_DATA-1:0] c_data;
  logic                         c_valid;
  logic                         c_ready;

  modport master (output c_addr, c_data, c_valid, input  c_ready);
  modport slave  (input  c_addr, c_data, c_valid, output c_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO; a full FIFO still accepts a push when the head is popped in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  // Head is forced to zero while empty so the output never shows stale storage.
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr_q] <= push_data;

endmodule

// File: rtl/uart_rx_param.sv
// Run-time configurable UART receiver: oversampled majority voting, parity/stop checks,
// break recovery and a ready/valid receive FIFO with overrun reporting.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int                           WIDTH_CONFIG_ADDR = 4,
  parameter int                           WIDTH_CONFIG_DATA = 16,
  parameter logic [WIDTH_CONFIG_ADDR-1:0] CFG_BASE_ADDR     = 4'b0100,
  parameter int                           MAX_DATABITS      = 9,
  parameter int                           OVERSAMPLE        = 16,
  parameter logic [WIDTH_CONFIG_DATA-1:0] DEFAULT_DIV       = 16'd27,
  parameter int                           FIFO_DEPTH        = 8,
  parameter int                           WIDTH_ERROR       = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in,
  uart_rx_param_if.slave          cfg,
  output logic [WIDTH_ERROR-1:0]  error,
  output logic                    valid_error,
  output logic [MAX_DATABITS-1:0] out,
  output logic                    valid_out,
  input  logic                    out_ready
);
  localparam int                           OS_W      = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]              OS_S0     = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0]              OS_S1     = OS_W'(OVERSAMPLE/2);
  localparam logic [OS_W-1:0]              OS_S2     = OS_W'(OVERSAMPLE/2 + 1);
  localparam logic [OS_W-1:0]              OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]                   MAX_DB    = 4'(MAX_DATABITS);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_CTRL = CFG_BASE_ADDR + WIDTH_CONFIG_ADDR'(REG_CTRL);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_DIV  = CFG_BASE_ADDR + WIDTH_CONFIG_ADDR'(REG_DIV);

  logic                         in_meta_q, in_sync_q, in_prev_q;
  logic [2:0]                   state_q, state_d;
  logic [WIDTH_CONFIG_DATA-1:0] div_cnt_q, div_cnt_d, div_q, div_d;
  logic [OS_W-1:0]              os_cnt_q, os_cnt_d;
  logic [3:0]                   bit_cnt_q, bit_cnt_d, db_q, db_d;
  logic [MAX_DATABITS-1:0]      data_q, data_d;
  logic                         s0_q, s0_d, s1_q, s1_d;
  logic                         par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                         stop2nd_q, stop2nd_d, stop2_q, stop2_d;
  logic [1:0]                   par_q, par_d;
  logic [WIDTH_ERROR-1:0]       error_q, error_d;
  logic                         verr_q, verr_d;

  logic start_edge, tick, vote_now, bit_end, vote, par_en, cfg_wr, push, fe;
  logic fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {in_meta_q, in_sync_q, in_prev_q} <= 3'b111;
    else        {in_meta_q, in_sync_q, in_prev_q} <= {in, in_meta_q, in_sync_q};
  end

  assign start_edge  = in_prev_q & ~in_sync_q;
  assign tick        = (div_cnt_q == div_q - 1'b1);
  assign vote_now    = tick && (os_cnt_q == OS_S2);
  assign bit_end     = tick && (os_cnt_q == OS_LAST);
  // Third sample is the live synchronised line at the last sampling tick.
  assign vote        = (s0_q & s1_q) | (s0_q & in_sync_q) | (s1_q & in_sync_q);
  assign par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign cfg.c_ready = (state_q == ST_IDLE);
  assign cfg_wr      = cfg.c_valid && cfg.c_ready;

  always_comb begin
    state_d   = state_q;   div_cnt_d = div_cnt_q; os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q; data_d    = data_q;    s0_d      = s0_q;
    s1_d      = s1_q;      par_err_d = par_err_q; frm_err_d = frm_err_q;
    stop2nd_d = stop2nd_q; db_d      = db_q;      par_d     = par_q;
    stop2_d   = stop2_q;   div_d     = div_q;     error_d   = error_q;
    verr_d    = 1'b0;      push      = 1'b0;      fe        = 1'b0;

    if (cfg_wr && cfg.c_addr == ADDR_CTRL) begin
      db_d    = clamp_databits(cfg.c_data[CTRL_DB_MSB:CTRL_DB_LSB], MAX_DB);
      par_d   = cfg.c_data[CTRL_PAR_MSB:CTRL_PAR_LSB];
      stop2_d = cfg.c_data[CTRL_STOP_BIT];
    end
    if (cfg_wr && cfg.c_addr == ADDR_DIV)
      div_d = (cfg.c_data == '0) ? WIDTH_CONFIG_DATA'(1) : cfg.c_data;

    if (state_q != ST_IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      if (tick && os_cnt_q == OS_S0) s0_d = in_sync_q;
      if (tick && os_cnt_q == OS_S1) s1_d = in_sync_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Bit phase restarts at the detected edge.
        div_cnt_d = '0;
        os_cnt_d  = '0;
        if (start_edge) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          data_d    = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          stop2nd_d = 1'b0;
        end
      end
      ST_START: begin
        if (vote_now && vote) state_d = ST_IDLE;
        else if (bit_end)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_now) data_d[bit_cnt_q] = vote;
        if (bit_end) begin
          if (bit_cnt_q == db_q - 4'd1) state_d = par_en ? ST_PARITY : ST_STOP;
          else                          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_PARITY: begin
        if (vote_now) par_err_d = (^data_q) ^ vote ^ (par_q == PAR_ODD);
        if (bit_end)  state_d = ST_STOP;
      end
      ST_STOP: begin
        if (vote_now) begin
          fe = frm_err_q | ~vote;
          // Frame ends at the mid-sample of the last stop bit.
          if (!stop2_q || stop2nd_q) begin
            if (fe || par_err_q) begin
              error_d             = '0;
              error_d[ERR_FRAME]  = fe;
              error_d[ERR_PARITY] = par_err_q;
              verr_d              = 1'b1;
            end else begin
              push = 1'b1;
            end
            state_d = fe ? ST_BREAK : ST_IDLE;
          end else begin
            frm_err_d = fe;
          end
        end else if (bit_end) begin
          stop2nd_d = 1'b1;
        end
      end
      ST_BREAK: if (in_sync_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (push && fifo_full && !out_ready) begin
      error_d              = '0;
      error_d[ERR_OVERRUN] = 1'b1;
      verr_d               = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;     div_cnt_q <= '0;         os_cnt_q  <= '0;
      bit_cnt_q <= '0;          data_q    <= '0;         s0_q      <= 1'b1;
      s1_q      <= 1'b1;        par_err_q <= 1'b0;       frm_err_q <= 1'b0;
      stop2nd_q <= 1'b0;        db_q      <= DEF_DATABITS;
      par_q     <= DEF_PARITY;  stop2_q   <= DEF_STOP2;  div_q     <= DEFAULT_DIV;
      error_q   <= '0;          verr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;     div_cnt_q <= div_cnt_d;  os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;   data_q    <= data_d;     s0_q      <= s0_d;
      s1_q      <= s1_d;        par_err_q <= par_err_d;  frm_err_q <= frm_err_d;
      stop2nd_q <= stop2nd_d;   db_q      <= db_d;
      par_q     <= par_d;       stop2_q   <= stop2_d;    div_q     <= div_d;
      error_q   <= error_d;     verr_q    <= verr_d;
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(MAX_DATABITS)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (data_q),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out)
  );

  assign error       = error_q;
  assign valid_error = verr_q;
  assign valid_out   = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised bench for uart_rx_param: frames are built bit-by-bit from the configured
// format and received data/errors are compared against the expected character stream.
`timescale 1ns/1ps
module tb_uart_rx_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [2:0] error;
  logic       valid_error;
  logic [8:0] out;
  logic       valid_out;

  uart_rx_param_if #(.WIDTH_CONFIG_ADDR(4), .WIDTH_CONFIG_DATA(16)) cfg_if ();

  uart_rx_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (rx),
    .cfg         (cfg_if),
    .error       (error),
    .valid_error (valid_error),
    .out         (out),
    .valid_out   (valid_out),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ve_cnt = 0;
  logic [2:0] last_err = '0;

  // Reference configuration as the receiver should currently see it.
  int m_nb, m_par, m_div;
  bit m_st2;

  always @(negedge clk) if (valid_error) begin ve_cnt++; last_err = error; end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_defaults();
    m_nb = 8; m_par = 0; m_st2 = 0; m_div = 27;
  endtask

  task automatic model_apply(input logic [3:0] a, input logic [15:0] d);
    if (a == 4'h4) begin
      m_nb  = (d[3:0] < 5) ? 5 : (d[3:0] > 9) ? 9 : int'(d[3:0]);
      m_par = int'(d[5:4]);
      m_st2 = d[6];
    end else if (a == 4'h5) begin
      m_div = (d == 0) ? 1 : int'(d);
    end
  endtask

  function automatic logic [8:0] exp_val(input logic [8:0] d);
    logic [8:0] r = '0;
    for (int i = 0; i < m_nb; i++) r[i] = d[i];
    return r;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, output logic acc);
    @(negedge clk);
    cfg_if.c_addr = a; cfg_if.c_data = d; cfg_if.c_valid = 1'b1;
    #1 acc = cfg_if.c_ready;
    @(negedge clk);
    cfg_if.c_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int cpb);
    rx = b;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input bit bad_par, input bit bad_stop);
    int cpb = m_div * 16;
    logic p = 1'b0;
    drive_bit(1'b0, cpb);
    for (int i = 0; i < m_nb; i++) begin drive_bit(d[i], cpb); p ^= d[i]; end
    if (m_par == 1 || m_par == 2) drive_bit(p ^ (m_par == 2) ^ bad_par, cpb);
    drive_bit(!bad_stop, cpb);
    if (m_st2) drive_bit(1'b1, cpb);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(output logic [8:0] q[$]);
    q = {};
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!valid_out) break;
      q.push_back(out);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic acc;
    cfg_if.c_valid = 1'b0; cfg_if.c_addr = '0; cfg_if.c_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_defaults();
    @(negedge clk);
    checks++; if (cfg_if.c_ready !== 1'b1) begin errors++; $display("FAIL reset_c_ready: got %b want 1", cfg_if.c_ready); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    checks++; if (out !== 9'h000) begin errors++; $display("FAIL reset_out: got %h want 000", out); end
    checks++; if ({valid_error, error} !== 4'b0) begin errors++; $display("FAIL reset_error: got %b/%b want 0/000", valid_error, error); end
    cfg_write(4'h5, 16'd1, acc);
    model_apply(4'h5, 16'd1);
  endtask

  task automatic test_basic();
    logic [8:0] q[$];
    int ve0 = ve_cnt;
    send_frame(9'h0A5, 0, 0);
    idle(4);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_out); end
    drain(q);
    checks++; if (q.size() != 1 || q[0] !== 9'h0A5) begin errors++; $display("FAIL basic_data: got %0d items first %h want 1 item 0a5", q.size(), (q.size() > 0) ? q[0] : 9'h1FF); end
    checks++; if (ve_cnt - ve0 != 0) begin errors++; $display("FAIL basic_no_error: got %0d pulses want 0", ve_cnt - ve0); end
  endtask

  task automatic test_parity();
    logic acc;
    logic [8:0] q[$];
    int ve0;
    cfg_write(4'h4, 16'h0057, acc);
    model_apply(4'h4, 16'h0057);
    send_frame(9'h055, 0, 0);
    idle(4);
    drain(q);
    checks++; if (q.size() != 1 || q[0] !== exp_val(9'h055)) begin errors++; $display("FAIL parity_good: got %0d items first %h want %h", q.size(), (q.size() > 0) ? q[0] : 9'h1FF, exp_val(9'h055)); end
    ve0 = ve_cnt;
    send_frame(9'h055, 1, 0);
    idle(4);
    checks++; if (ve_cnt - ve0 != 1 || last_err !== 3'b001) begin errors++; $display("FAIL parity_bad: got %0d pulses err %b want 1 pulse err 001", ve_cnt - ve0, last_err); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL parity_no_push: got valid_out %b want 0", valid_out); end
  endtask

  task automatic test_break();
    logic acc;
    logic [8:0] q[$];
    int ve0;
    cfg_write(4'h4, 16'h0008, acc);
    model_apply(4'h4, 16'h0008);
    ve0 = ve_cnt;
    send_frame(9'h0F0, 0, 1);
    rx = 1'b0;
    repeat (20 * 16 * m_div) @(negedge clk);
    checks++; if (cfg_if.c_ready !== 1'b0) begin errors++; $display("FAIL break_busy: got c_ready %b want 0", cfg_if.c_ready); end
    idle(40);
    checks++; if (ve_cnt - ve0 != 1 || last_err !== 3'b010) begin errors++; $display("FAIL break_error: got %0d pulses err %b want 1 pulse err 010", ve_cnt - ve0, last_err); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL break_no_push: got valid_out %b want 0", valid_out); end
    send_frame(9'h03C, 0, 0);
    idle(4);
    drain(q);
    checks++; if (q.size() != 1 || q[0] !== 9'h03C) begin errors++; $display("FAIL break_recover: got %0d items first %h want 03c", q.size(), (q.size() > 0) ? q[0] : 9'h1FF); end
  endtask

  task automatic test_glitch();
    int ve0 = ve_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(40);
    checks++; if (valid_out !== 1'b0 || ve_cnt != ve0) begin errors++; $display("FAIL glitch_ignored: got valid_out %b pulses %0d want 0 0", valid_out, ve_cnt - ve0); end
    checks++; if (cfg_if.c_ready !== 1'b1) begin errors++; $display("FAIL glitch_idle: got c_ready %b want 1", cfg_if.c_ready); end
  endtask

  task automatic test_overrun();
    logic [8:0] sent[$];
    logic [8:0] q[$];
    logic [8:0] d;
    int ve0 = ve_cnt;
    for (int i = 0; i < 9; i++) begin
      d = 9'($urandom_range(0, 255));
      sent.push_back(d);
      send_frame(d, 0, 0);
    end
    idle(8);
    checks++; if (ve_cnt - ve0 != 1 || last_err !== 3'b100) begin errors++; $display("FAIL overrun_error: got %0d pulses err %b want 1 pulse err 100", ve_cnt - ve0, last_err); end
    drain(q);
    checks++; if (q.size() != 8) begin errors++; $display("FAIL overrun_count: got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      checks++; if (q[i] !== exp_val(sent[i])) begin errors++; $display("FAIL overrun_order[%0d]: got %h want %h", i, q[i], exp_val(sent[i])); end
    end
  endtask

  task automatic test_cfg_midframe();
    logic acc;
    logic [8:0] q[$];
    logic [8:0] d0, d1;
    d0 = 9'($urandom_range(0, 255));
    d1 = 9'($urandom_range(0, 255));
    fork
      send_frame(d0, 0, 0);
      begin repeat (5 * 16 * m_div) @(negedge clk); cfg_write(4'h5, 16'd5, acc); end
    join
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL cfg_busy: got c_ready %b want 0", acc); end
    idle(4);
    send_frame(d1, 0, 0);
    idle(4);
    drain(q);
    checks++; if (q.size() != 2 || q[0] !== d0 || q[1] !== d1) begin errors++; $display("FAIL cfg_unchanged: got %0d items want %h %h", q.size(), d0, d1); end
    cfg_write(4'h5, 16'd2, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL cfg_idle_accept: got c_ready %b want 1", acc); end
    model_apply(4'h5, 16'd2);
    send_frame(d1 ^ 9'h0FF, 0, 0);
    idle(4);
    drain(q);
    checks++; if (q.size() != 1 || q[0] !== (d1 ^ 9'h0FF)) begin errors++; $display("FAIL cfg_new_div: got %0d items want %h", q.size(), d1 ^ 9'h0FF); end
    cfg_write(4'h3, 16'h0057, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL cfg_outside_ready: got c_ready %b want 1", acc); end
    cfg_write(4'h5, 16'd0, acc);
    model_apply(4'h5, 16'd0);
    send_frame(d0, 0, 0);
    idle(4);
    drain(q);
    checks++; if (q.size() != 1 || q[0] !== d0) begin errors++; $display("FAIL cfg_outside_ignored: got %0d items want %h", q.size(), d0); end
  endtask

  task automatic test_random();
    logic acc;
    logic [15:0] ctrl;
    logic [8:0] sent[$];
    logic [8:0] q[$];
    logic [8:0] d;
    int n, ve0;
    for (int r = 0; r < 6; r++) begin
      ctrl = 16'($urandom_range(0, 127));
      cfg_write(4'h4, ctrl, acc);
      model_apply(4'h4, ctrl);
      sent = {};
      ve0 = ve_cnt;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        d = 9'($urandom_range(0, 511));
        sent.push_back(exp_val(d));
        send_frame(d, 0, 0);
      end
      idle(6);
      drain(q);
      checks++; if (q.size() != n || ve_cnt != ve0) begin errors++; $display("FAIL random_count[%0d]: ctrl %h got %0d items %0d errs want %0d 0", r, ctrl, q.size(), ve_cnt - ve0, n); end
      for (int i = 0; i < n && i < q.size(); i++) begin
        checks++; if (q[i] !== sent[i]) begin errors++; $display("FAIL random_data[%0d.%0d]: ctrl %h got %h want %h", r, i, ctrl, q[i], sent[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic acc;
    logic [8:0] q[$];
    cfg_write(4'h4, 16'h0026, acc);
    model_apply(4'h4, 16'h0026);
    send_frame(9'h015, 0, 0);
    idle(4);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid_out %b want 1", valid_out); end
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (cfg_if.c_ready !== 1'b1 || valid_out !== 1'b0 || out !== 9'h000) begin errors++; $display("FAIL rstmid_outputs: got c_ready %b valid_out %b out %h want 1 0 000", cfg_if.c_ready, valid_out, out); end
    checks++; if (error !== 3'b000 || valid_error !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b/%b want 000/0", error, valid_error); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    model_defaults();
    idle(4);
    send_frame(9'h0C3, 0, 0);
    idle(4);
    drain(q);
    checks++; if (q.size() != 1 || q[0] !== 9'h0C3) begin errors++; $display("FAIL rstmid_defaults: got %0d items first %h want 0c3", q.size(), (q.size() > 0) ? q[0] : 9'h1FF); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_cfg_midframe();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, run-time configurable UART receiver; successor to the fixed 8N1/8N2 receive path.
- Adds programmable data bits (5..MAX_DATABITS), none/even/odd parity, 1/2 stop bits and a programmable baud divisor.
- Adds 3-sample majority voting, false-start rejection, break recovery and an output FIFO with ready/valid backpressure plus overrun reporting.
- Sits between the serial pin and the command/display logic; configured over the shared c_addr/c_data/c_valid/c_ready bus.

Parameters:
- WIDTH_CONFIG_ADDR, 4, config bus address width.
- WIDTH_CONFIG_DATA, 16, config bus data width.
- CFG_BASE_ADDR, 4'b0100, UART register window base; two registers at +0, +1.
- MAX_DATABITS, 9, widest supported character; also the width of out.
- OVERSAMPLE, 16, oversample ticks per bit, even and >=8.
- DEFAULT_DIV, 16'd27, reset value of the baud divisor (clk cycles per tick).
- FIFO_DEPTH, 8, receive FIFO entries, power of 2.
- WIDTH_ERROR, 3, error code width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  1  asynchronous serial line, idle high.
- c_addr  in  WIDTH_CONFIG_ADDR  config register address.
- c_data  in  WIDTH_CONFIG_DATA  config write data.
- c_valid  in  1  config write request.
- c_ready  out  1  1 = config write accepted this cycle.
- error  out  WIDTH_ERROR  last error code: bit0 parity, bit1 framing, bit2 overrun.
- valid_error  out  1  one-cycle pulse qualifying error.
- out  out  MAX_DATABITS  FIFO head, zero-extended above the configured data bits.
- valid_out  out  1  FIFO not empty.
- out_ready  in  1  consumer pops the head when valid_out && out_ready.

Behaviour:
- Reset values:
  - all outputs 0, except c_ready=1.
  - FIFO empty; state IDLE.
  - config defaults: databits=8, parity=none, stopbits=1, div=DEFAULT_DIV.
- Config registers:
  - +0 ctrl: [3:0] databits (values <5 clamp to 5, >MAX_DATABITS clamp to MAX_DATABITS); [5:4] parity (00 none, 01 even, 10 odd, 11 treated as none); [6] stopbits (0 = 1 bit, 1 = 2 bits).
  - +1 baud divisor; a value of 0 is treated as 1.
  - c_ready = (state==IDLE).
  - A write with c_valid && c_ready && address in the window updates the register on that clock edge.
  - Writes outside the window are ignored, and c_ready is unaffected by them.
  - New config applies from the next frame. A start edge in the same cycle as a write uses the new values.
- Input path:
  - 2-FF synchroniser on in; start-edge detect on the synchronised line.
  - Tick counter counts div clocks per tick. It is reset on start detect so that bit phase aligns to the edge.
- States and transitions:
  - IDLE → START on a synchronised falling edge.
  - START: majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
    - Result 1 → IDLE (false start, no error).
    - Result 0 → DATA at bit end.
  - DATA: captures databits bits LSB-first, one majority vote per bit. → PARITY if parity is enabled, otherwise → STOP.
  - PARITY: even/odd check over the data bits; a mismatch sets the parity flag.
  - STOP: each configured stop bit must vote 1, otherwise the framing flag is set. Second-bit sampling still occurs after a first-bit failure. Frame end is at the mid-sample of the last stop bit, which allows back-to-back frames.
  - Frame end, no error → push data to the FIFO.
  - Frame end, parity or framing error → no push. error <= flags, valid_error pulses 1 cycle.
  - After a framing error → BREAK: wait until the synchronised line is 1, then → IDLE.
- FIFO:
  - Pushing while full → data dropped, error=3'b100, valid_error pulse.
  - Exception: if a pop occurs in the same cycle while full, the push is accepted and no overrun is raised.
  - Push and pop in the same cycle while not full → count is unchanged.
  - Pop while empty is ignored.
- error holds its last code until the next error event.
- The state machine is not affected by FIFO state.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - the parity mode encoding.
  - the error bit indices.
  - the register offsets and ctrl field positions.
  - default config constants.
- Sub-module uart_rx_fifo: synchronous FIFO (FIFO_DEPTH x MAX_DATABITS) with push/pop/full/empty, same clk/rst_n.

Test Plan:
- Default config, div=1, OVERSAMPLE=16, send 8N1 byte 0xA5 → valid_out after the frame, out=9'h0A5, no valid_error.
- Write ctrl=7'b1_01_0111 (7 bits, even parity, 2 stop), send 0x55 with correct parity → out=9'h055. Same frame with the parity bit flipped → error=3'b001 pulse, FIFO stays empty.
- Stop bit driven 0, line held low 20 bit-times then released → error=3'b010 pulse, no push. The next valid frame 0x3C is received correctly.
- 2-tick low glitch on an idle line → no frame, no error, state returns to IDLE.
- out_ready=0, send FIFO_DEPTH+1 frames → first 8 retained in order. 9th gives error=3'b100, and valid_error pulses exactly once.
- Config write attempted mid-frame → c_ready=0, register unchanged. Write retried in IDLE is accepted. Reset asserted mid-frame → all outputs at reset values, config back to defaults.
